// File: rtl/channel_rr_merge_if.sv
// Handshake bundle for the round-robin merge: K valid/data/ack inputs and
// one registered valid/data output carrying {source tag, data}.
interface channel_rr_merge_if #(
    parameter int unsigned N = 4,
    parameter int unsigned K = 4
);
    localparam int unsigned TAG_W = $clog2(K);
    localparam int unsigned OUT_W = TAG_W + N;

    logic [K-1:0]          in_v;
    logic [K-1:0][N-1:0]   in_d;
    logic [K-1:0]          in_a;
    logic                  out_v;
    logic [OUT_W-1:0]      out_d;
    logic                  out_a;

    // Producer side plus downstream consumer (testbench / surrounding logic)
    modport master (
        output in_v,
        output in_d,
        input  in_a,
        input  out_v,
        input  out_d,
        output out_a
    );

    // The merge block itself
    modport slave (
        input  in_v,
        input  in_d,
        output in_a,
        output out_v,
        output out_d,
        input  out_a
    );
endinterface

// File: rtl/channel_rr_merge.sv
// Round-robin merge of K valid/data-ack input channels onto one output channel.
// A one-entry output register sustains one transfer per clock; tag = source index.
module channel_rr_merge #(
    parameter int unsigned N = 4,
    parameter int unsigned K = 4
) (
    input  logic               clk,
    input  logic               reset,
    channel_rr_merge_if.slave  bus
);
    localparam int unsigned TAG_W = $clog2(K);
    localparam int unsigned OUT_W = TAG_W + N;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              r_state;
    logic [TAG_W-1:0]    r_ptr;
    logic                r_out_v;
    logic [OUT_W-1:0]    r_out_d;

    logic                w_load;
    logic                w_any;
    logic [TAG_W-1:0]    w_idx;
    logic [K-1:0]        w_gnt;

    // The output register can take a new word when empty or being drained this edge
    assign w_load = (r_state == IDLE) | bus.out_a;

    // Round-robin search from ptr+1, wrapping, with ptr itself considered last
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_gnt = '0;
        for (int unsigned off = 1; off <= K; off++) begin
            int unsigned sum;
            logic [TAG_W-1:0] cand;
            sum  = 32'(r_ptr) + off;
            if (sum >= K) begin
                sum = sum - K;
            end
            cand = TAG_W'(sum);
            if (!w_any && bus.in_v[cand]) begin
                w_any       = 1'b1;
                w_idx       = cand;
                w_gnt[cand] = 1'b1;
            end
        end
    end

    // Ack is combinational and suppressed while reset is held
    assign bus.in_a = (reset || !w_load) ? '0 : w_gnt;

    // Output holding register and priority pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= TAG_W'(K - 1);
            r_out_v <= 1'b0;
            r_out_d <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_state <= FULL;
                r_ptr   <= w_idx;
                r_out_v <= 1'b1;
                r_out_d <= {w_idx, bus.in_d[w_idx]};
            end else begin
                r_state <= IDLE;
                r_out_v <= 1'b0;
            end
        end
    end

    assign bus.out_v = r_out_v;
    assign bus.out_d = r_out_d;
endmodule

// File: tb/tb_channel_rr_merge.sv
// Directed bench for channel_rr_merge: stimulus pushes hand-computed words into
// a queue, an independent monitor pops and compares on every output transfer.
module tb_channel_rr_merge;
    localparam int unsigned N = 4;
    localparam int unsigned K = 4;
    localparam int unsigned W = 6;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [W-1:0] exp_q[$];

    channel_rr_merge_if #(.N(N), .K(K)) bus ();

    channel_rr_merge #(.N(N), .K(K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] tag, input logic [3:0] data);
        exp_q.push_back({tag, data});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every output transfer against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_v === 1'b1 && bus.out_a === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h expected none at %0t", bus.out_d, $time);
                end else begin
                    check("out_word", 32'(bus.out_d), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] d0;
        n_checks = 0;
        n_fail   = 0;

        // Reset with all inputs requesting
        reset     = 1'b1;
        bus.in_v  = 4'hF;
        bus.in_d  = {4'h8, 4'h7, 4'h6, 4'h5};
        bus.out_a = 1'b0;
        repeat (3) step();
        check("rst_out_v", 32'(bus.out_v), 32'd0);
        check("rst_out_d", 32'(bus.out_d), 32'd0);
        check("rst_in_a",  32'(bus.in_a),  32'd0);
        reset = 1'b0;
        #1;
        check("first_gnt", 32'(bus.in_a), 32'b0001);

        // All valid, consumer always ready: tags 0,1,2,3 repeating, one per clock
        bus.out_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] t;
            logic [3:0] dv;
            t  = 2'(k % 4);
            dv = 4'(5 + (k % 4));
            push(t, dv);
            #1;
            check("rr_in_a", 32'(bus.in_a), 32'(4'b0001 << t));
            step();
        end
        bus.in_v = 4'h0;
        step();
        check("rr_idle", 32'(bus.out_v), 32'd0);

        // Backpressure: word from input 2 held stable, no further acks
        bus.out_a = 1'b0;
        bus.in_v  = 4'b0100;
        bus.in_d  = {4'h8, 4'hA, 4'h6, 4'h5};
        push(2'd2, 4'hA);
        #1;
        check("bp_load_ack", 32'(bus.in_a), 32'b0100);
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_out_v", 32'(bus.out_v), 32'd1);
            check("bp_out_d", 32'(bus.out_d), 32'h2A);
            check("bp_in_a",  32'(bus.in_a),  32'd0);
            step();
        end
        bus.in_v  = 4'h0;
        bus.out_a = 1'b1;
        step();
        check("bp_drained", 32'(bus.out_v), 32'd0);

        // Set ptr=1, then inputs 0 and 3: wrap order grants 3 before 0
        bus.in_v = 4'b0010;
        bus.in_d = {4'h9, 4'h8, 4'h3, 4'h7};
        push(2'd1, 4'h3);
        #1;
        check("wrap_set_ptr", 32'(bus.in_a), 32'b0010);
        step();
        bus.in_v = 4'b1001;
        push(2'd3, 4'h9);
        #1;
        check("wrap_first", 32'(bus.in_a), 32'b1000);
        step();
        push(2'd0, 4'h7);
        #1;
        check("wrap_second", 32'(bus.in_a), 32'b0001);
        step();
        bus.in_v = 4'h0;
        step();
        check("wrap_idle", 32'(bus.out_v), 32'd0);

        // Reset while FULL: held word is discarded and never acked
        bus.out_a = 1'b0;
        bus.in_v  = 4'b0001;
        bus.in_d  = {4'h9, 4'h8, 4'h3, 4'hC};
        #1;
        check("mid_load_ack", 32'(bus.in_a), 32'b0001);
        step();
        bus.in_v = 4'h0;
        check("mid_full_v", 32'(bus.out_v), 32'd1);
        check("mid_full_d", 32'(bus.out_d), 32'h0C);
        bus.in_v = 4'hF;
        reset    = 1'b1;
        #1;
        check("mid_rst_out_v", 32'(bus.out_v), 32'd0);
        check("mid_rst_out_d", 32'(bus.out_d), 32'd0);
        check("mid_rst_in_a",  32'(bus.in_a),  32'd0);
        bus.out_a = 1'b1;
        repeat (2) step();
        d0 = 4'hE;
        bus.in_d = {4'h9, 4'h8, 4'h3, d0};
        reset = 1'b0;
        push(2'd0, d0);
        #1;
        check("post_rst_gnt", 32'(bus.in_a), 32'b0001);
        step();
        bus.in_v = 4'h0;
        step();

        // Consumer ack while output empty has no effect
        for (int k = 0; k < 2; k++) begin
            check("idle_out_a", 32'(bus.out_v), 32'd0);
            step();
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
